// File: rtl/tl_pkg.sv
// tl_pkg: shared state encoding, light patterns and 7-segment encoding for the traffic light controller
package tl_pkg;

    typedef enum logic [2:0] {
        ST_HG    = 3'd0,
        ST_HY    = 3'd1,
        ST_AR1   = 3'd2,
        ST_CG    = 3'd3,
        ST_CY    = 3'd4,
        ST_AR2   = 3'd5,
        ST_FLASH = 3'd6
    } tl_state_e;

    // LEDR layout: [9:7] HWY R/Y/G, [2:0] CTRY R/Y/G
    localparam logic [9:0] LEDR_HG    = 10'b0010000100;
    localparam logic [9:0] LEDR_HY    = 10'b0100000100;
    localparam logic [9:0] LEDR_AR    = 10'b1000000100;
    localparam logic [9:0] LEDR_CG    = 10'b1000000001;
    localparam logic [9:0] LEDR_CY    = 10'b1000000010;
    localparam logic [9:0] LEDR_FLASH = 10'b0100000100;

    // Segment vectors are [0:6] = a..g, active-low
    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_F     = 7'b0111000;

    function automatic logic [0:6] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_param_tick_gen.sv
// tl_tick_gen: divides clk by DIV into a one-cycle tick pulse
//   clk   in  system clock
//   rst_n in  synchronous active-low reset, divider restarts at 0
//   tick  out high for one cycle when the divider reaches DIV-1
module tl_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = cnt_q == W'(DIV - 1);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/traffic_light_ctrl_param.sv
// traffic_light_ctrl_param: highway/country-road light controller with sensor, max-out, clearance and night flash
//   CLOCK_50 in  system clock
//   KEY[0]   in  synchronous active-low reset
//   SW[0]    in  country-road car sensor; SW[1] night flash request
//   LEDG[7]  out tick heartbeat
//   LEDR     out [9:7] HWY R/Y/G, [2:0] CTRY R/Y/G
//   HEX1:0   out countdown (tens blank when zero), HEX2 state index, HEX3 'F' in flash
module traffic_light_ctrl_param
    import tl_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TICK_HZ       = 1,
    parameter int MIN_HWY_GREEN = 10,
    parameter int YELLOW_T      = 3,
    parameter int ALL_RED_T     = 1,
    parameter int MAX_CTRY_GRN  = 20,
    parameter int CNT_W         = 7
) (
    input  logic       CLOCK_50,
    input  logic [0:0] KEY,
    input  logic [1:0] SW,
    output logic [7:7] LEDG,
    output logic [9:0] LEDR,
    output logic [0:6] HEX0,
    output logic [0:6] HEX1,
    output logic [0:6] HEX2,
    output logic [0:6] HEX3
);

    localparam logic [CNT_W-1:0] T_HG = CNT_W'(MIN_HWY_GREEN - 1);
    localparam logic [CNT_W-1:0] T_Y  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] T_AR = CNT_W'(ALL_RED_T - 1);
    localparam logic [CNT_W-1:0] T_CG = CNT_W'(MAX_CTRY_GRN - 1);
    localparam logic [3:0]       RST_ONES = 4'(MIN_HWY_GREEN % 10);
    localparam logic [3:0]       RST_TENS = 4'(MIN_HWY_GREEN / 10);

    logic             rst_n, tick;
    tl_state_e        state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d, cnt;
    logic             lit_q, lit_d, hb_q;
    logic [3:0]       tens, ones;
    logic [9:0]       ledr_q, ledr_d;
    logic [0:6]       hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d, hex3_q, hex3_d;

    assign rst_n = KEY[0];

    tl_tick_gen #(.DIV(CLK_HZ / TICK_HZ)) u_tick (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q <= ST_HG;
            timer_q <= T_HG;
            lit_q   <= 1'b0;
            hb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            lit_q   <= lit_d;
            hb_q    <= hb_q ^ tick;
        end
    end

    // Flash request beats every other exit; CG's sensor release beats its timer.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        lit_d   = lit_q;
        if (tick) begin
            if (SW[1] && state_q != ST_FLASH) begin
                state_d = ST_FLASH;
                timer_d = '0;
                lit_d   = 1'b1;
            end else if (state_q == ST_FLASH) begin
                lit_d = !lit_q;
                if (!SW[1]) begin
                    state_d = ST_AR2;
                    timer_d = T_AR;
                end
            end else if (state_q == ST_CG && !SW[0]) begin
                state_d = ST_CY;
                timer_d = T_Y;
            end else if (timer_q != '0) begin
                timer_d = timer_q - 1'b1;
            end else begin
                case (state_q)
                    ST_HG: if (SW[0]) begin
                        state_d = ST_HY;
                        timer_d = T_Y;
                    end
                    ST_HY: begin
                        state_d = ST_AR1;
                        timer_d = T_AR;
                    end
                    ST_AR1: begin
                        state_d = ST_CG;
                        timer_d = T_CG;
                    end
                    ST_CG: begin
                        state_d = ST_CY;
                        timer_d = T_Y;
                    end
                    ST_CY: begin
                        state_d = ST_AR2;
                        timer_d = T_AR;
                    end
                    default: begin
                        state_d = ST_HG;
                        timer_d = T_HG;
                    end
                endcase
            end
        end
    end

    always_comb begin
        cnt    = timer_q + 1'b1;
        tens   = 4'(cnt / CNT_W'(10));
        ones   = 4'(cnt % CNT_W'(10));
        ledr_d = state_q == ST_HG    ? LEDR_HG :
                 state_q == ST_HY    ? LEDR_HY :
                 state_q == ST_CG    ? LEDR_CG :
                 state_q == ST_CY    ? LEDR_CY :
                 state_q == ST_FLASH ? (lit_q ? LEDR_FLASH : 10'b0) : LEDR_AR;
        hex0_d = state_q == ST_FLASH ? SEG_BLANK : seg7(ones);
        hex1_d = (state_q == ST_FLASH || tens == 4'd0) ? SEG_BLANK : seg7(tens);
        hex2_d = seg7(4'(state_q));
        hex3_d = state_q == ST_FLASH ? SEG_F : SEG_BLANK;
    end

    // Reset loads the displays directly so they are valid on the reset cycle itself.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            ledr_q <= LEDR_HG;
            hex0_q <= seg7(RST_ONES);
            hex1_q <= RST_TENS == 4'd0 ? SEG_BLANK : seg7(RST_TENS);
            hex2_q <= seg7(4'd0);
            hex3_q <= SEG_BLANK;
        end else begin
            ledr_q <= ledr_d;
            hex0_q <= hex0_d;
            hex1_q <= hex1_d;
            hex2_q <= hex2_d;
            hex3_q <= hex3_d;
        end
    end

    assign LEDG[7] = hb_q;
    assign LEDR    = ledr_q;
    assign HEX0    = hex0_q;
    assign HEX1    = hex1_q;
    assign HEX2    = hex2_q;
    assign HEX3    = hex3_q;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// tb_traffic_light_ctrl_param: directed scenarios plus random sensor/flash/reset traffic checked against a tick-level model
module tb_traffic_light_ctrl_param;

    localparam int DIV  = 4;
    localparam int MIN  = 3;
    localparam int YT   = 2;
    localparam int ART  = 1;
    localparam int MAXC = 5;
    localparam logic [0:6] BLANK = 7'b1111111;
    localparam logic [0:6] SEGF  = 7'b0111000;

    logic       clk = 1'b0;
    logic [0:0] key = 1'b0;
    logic [1:0] sw  = 2'b00;
    logic [7:7] ledg;
    logic [9:0] ledr;
    logic [0:6] hex0, hex1, hex2, hex3;

    int errs = 0;
    int checks = 0;

    logic [0:6] segtab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    traffic_light_ctrl_param #(
        .CLK_HZ(DIV), .TICK_HZ(1), .MIN_HWY_GREEN(MIN), .YELLOW_T(YT),
        .ALL_RED_T(ART), .MAX_CTRY_GRN(MAXC), .CNT_W(7)
    ) dut (
        .CLOCK_50(clk), .KEY(key), .SW(sw), .LEDG(ledg), .LEDR(ledr),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: state 0..6 in light-sequence order, el = ticks already spent in that state.
    int   m_st = 0, m_el = 0, m_ph = 0;
    bit   m_tick = 0, m_valid = 0;
    logic       e_hb = 1'b0;
    logic [9:0] e_ledr;
    logic [0:6] e_hex0, e_hex1, e_hex2, e_hex3;

    function automatic int dur(int st);
        case (st)
            0:       return MIN;
            1, 4:    return YT;
            3:       return MAXC;
            default: return ART;
        endcase
    endfunction

    task automatic set_exp(int st, int el);
        int cd;
        cd = st == 0 ? ((MIN - el) > 1 ? MIN - el : 1) : dur(st) - el;
        case (st)
            0:       e_ledr = 10'b0010000100;
            1:       e_ledr = 10'b0100000100;
            3:       e_ledr = 10'b1000000001;
            4:       e_ledr = 10'b1000000010;
            6:       e_ledr = (el % 2 == 0) ? 10'b0100000100 : 10'b0;
            default: e_ledr = 10'b1000000100;
        endcase
        e_hex0 = st == 6 ? BLANK : segtab[cd % 10];
        e_hex1 = (st == 6 || cd < 10) ? BLANK : segtab[cd / 10];
        e_hex2 = segtab[st];
        e_hex3 = st == 6 ? SEGF : BLANK;
    endtask

    task automatic advance(logic [1:0] s);
        int  n;
        bit  go;
        if (s[1] && m_st != 6) begin
            m_st = 6;
            m_el = 0;
        end else if (m_st == 6) begin
            if (!s[1]) begin
                m_st = 5;
                m_el = 0;
            end else m_el++;
        end else begin
            n = m_el + 1;
            case (m_st)
                0:       go = s[0] && n >= MIN;
                3:       go = !s[0] || n >= MAXC;
                default: go = n >= dur(m_st);
            endcase
            if (go) begin
                m_st = m_st == 5 ? 0 : m_st + 1;
                m_el = 0;
            end else m_el = n > 99 ? 99 : n;
        end
    endtask

    // Outputs seen after an edge reflect the model state from before that edge.
    always @(posedge clk) begin
        if (!key[0]) begin
            m_valid = 1;
            m_st    = 0;
            m_el    = 0;
            m_ph    = 0;
            m_tick  = 0;
            e_hb    = 1'b0;
            set_exp(0, 0);
        end else if (m_valid) begin
            set_exp(m_st, m_el);
            m_tick = m_ph == DIV - 1;
            m_ph   = m_tick ? 0 : m_ph + 1;
            if (m_tick) begin
                e_hb = ~e_hb;
                advance(sw);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("LEDR", 32'(ledr), 32'(e_ledr));
            chk("LEDG7", 32'(ledg[7]), 32'(e_hb));
            chk("HEX0", 32'(hex0), 32'(e_hex0));
            chk("HEX1", 32'(hex1), 32'(e_hex1));
            chk("HEX2", 32'(hex2), 32'(e_hex2));
            chk("HEX3", 32'(hex3), 32'(e_hex3));
            if (e_hex3 == BLANK) begin
                chk("hwy_onehot", $countones(ledr[9:7]), 1);
                chk("ctry_onehot", $countones(ledr[2:0]), 1);
                chk("both_green", 32'(ledr[7] & ledr[0]), 0);
            end
        end
    end

    task automatic to_tick();
        int k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!m_tick && k < 12);
        checks++;
        if (!m_tick) begin
            errs++;
            $display("FAIL tick_wait: no tick within %0d cycles", k);
        end
    endtask

    task automatic tick_out(int n = 1);
        repeat (n) begin
            to_tick();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(logic [1:0] s);
        @(posedge clk);
        #1;
        key = 1'b0;
        @(posedge clk);
        #1;
        key = 1'b1;
        sw  = s;
    endtask

    initial begin
        key = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        key = 1'b1;
        chk("rst_LEDR", 32'(ledr), 32'(10'b0010000100));
        chk("rst_HEX0", 32'(hex0), 32'(7'b0000110));
        chk("rst_HEX1", 32'(hex1), 32'(7'b1111111));
        chk("rst_HEX2", 32'(hex2), 32'(7'b0000001));
        chk("rst_HEX3", 32'(hex3), 32'(7'b1111111));
        chk("rst_LEDG", 32'(ledg[7]), 0);

        // 1: no car keeps highway green, countdown settles on 1
        tick_out(40);
        chk("s1_LEDR", 32'(ledr), 32'(10'b0010000100));
        chk("s1_HEX0", 32'(hex0), 32'(7'b1001111));

        // 2: full cycle with country green maxing out
        do_reset(2'b01);
        tick_out(3);
        chk("s2_HY", 32'(hex2), 32'(7'b1001111));
        chk("s2_HY_LEDR", 32'(ledr), 32'(10'b0100000100));
        tick_out(2);
        chk("s2_AR1", 32'(hex2), 32'(7'b0010010));
        tick_out(1);
        chk("s2_CG", 32'(hex2), 32'(7'b0000110));
        chk("s2_CG_LEDR", 32'(ledr), 32'(10'b1000000001));
        tick_out(4);
        chk("s2_CG_hold", 32'(hex2), 32'(7'b0000110));
        tick_out(1);
        chk("s2_CY", 32'(hex2), 32'(7'b1001100));
        tick_out(2);
        chk("s2_AR2", 32'(hex2), 32'(7'b0100100));
        tick_out(1);
        chk("s2_HG", 32'(hex2), 32'(7'b0000001));
        chk("s2_HG_HEX0", 32'(hex0), 32'(7'b0000110));

        // 3: sensor drops on the second CG tick
        do_reset(2'b01);
        tick_out(6);
        to_tick();
        sw = 2'b00;
        to_tick();
        chk("s3_still_CG", 32'(ledr), 32'(10'b1000000001));
        @(posedge clk);
        #1;
        chk("s3_CY", 32'(ledr), 32'(10'b1000000010));

        // 4: flash request during HY, then release through AR2
        do_reset(2'b01);
        tick_out(3);
        sw = 2'b11;
        tick_out(1);
        chk("s4_lit", 32'(ledr), 32'(10'b0100000100));
        chk("s4_F", 32'(hex3), 32'(7'b0111000));
        tick_out(1);
        chk("s4_dark", 32'(ledr), 0);
        tick_out(1);
        chk("s4_lit2", 32'(ledr), 32'(10'b0100000100));
        sw = 2'b00;
        tick_out(1);
        chk("s4_AR2", 32'(ledr), 32'(10'b1000000100));
        tick_out(1);
        chk("s4_HG_HEX0", 32'(hex0), 32'(7'b0000110));

        // 5: flash wins over a ready sensor exit
        do_reset(2'b00);
        tick_out(3);
        sw = 2'b11;
        tick_out(1);
        chk("s5_flash", 32'(hex2), 32'(7'b0100000));

        // 6: reset pulse landing on a tick cycle in CG
        do_reset(2'b01);
        tick_out(6);
        to_tick();
        repeat (3) @(posedge clk);
        #1;
        key = 1'b0;
        @(posedge clk);
        #1;
        key = 1'b1;
        chk("s6_LEDR", 32'(ledr), 32'(10'b0010000100));
        chk("s6_HEX2", 32'(hex2), 32'(7'b0000001));
        chk("s6_LEDG", 32'(ledg[7]), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("s6_no_early_tick", 32'(ledg[7]), 0);
        @(posedge clk);
        #1;
        chk("s6_tick_at_4", 32'(ledg[7]), 1);

        // random traffic: sensor, flash and occasional reset pulses
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            if (!key[0]) key = 1'b1;
            else if ($urandom_range(0, 299) == 0) key = 1'b0;
            if ($urandom_range(0, 9) == 0) sw[0] = ~sw[0];
            if ($urandom_range(0, 39) == 0) sw[1] = ~sw[1];
        end
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
